// File: rtl/ov7670_seq_controller.sv
// OV7670 bring-up sequencer: power/reset timing, then one SCCB write per table entry.
// Optional macro SCCB_WATCHDOG_EN adds a timeout on the i2c_taken handshake (ERROR state).
module ov7670_seq_controller #(
  parameter int          ADDR_W         = 8,
  parameter int          TABLE_LEN      = 75,
  parameter logic [7:0]  DEV_ID         = 8'h42,
  parameter int          PWRUP_CYCLES   = 1000,
  parameter int          RESET_CYCLES   = 1000,
  parameter int          SETTLE_CYCLES  = 100000,
  parameter int          GAP_CYCLES     = 16,
  parameter logic [7:0]  DELAY_TAG      = 8'hF0,
  parameter int          DELAY_UNIT     = 1000,
  parameter logic [15:0] END_TAG        = 16'hFFFF,
  parameter int          TIMEOUT_CYCLES = 65535
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              restart,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [15:0]       rom_data,
  output logic              i2c_send,
  input  logic              i2c_taken,
  output logic [7:0]        i2c_id,
  output logic [7:0]        i2c_reg,
  output logic [7:0]        i2c_value,
  output logic              cam_pwdn,
  output logic              cam_reset,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [ADDR_W:0]   writes_done
);

  localparam logic [3:0] S_PWRDN   = 4'd0;
  localparam logic [3:0] S_RST     = 4'd1;
  localparam logic [3:0] S_SETTLE  = 4'd2;
  localparam logic [3:0] S_FETCH   = 4'd3;
  localparam logic [3:0] S_DECODE  = 4'd4;
  localparam logic [3:0] S_DELAY   = 4'd5;
  localparam logic [3:0] S_SEND    = 4'd6;
  localparam logic [3:0] S_GAP     = 4'd7;
  localparam logic [3:0] S_ADVANCE = 4'd8;
  localparam logic [3:0] S_DONE    = 4'd9;
  localparam logic [3:0] S_ERROR   = 4'd10;

  localparam logic [ADDR_W:0] LAST = (ADDR_W+1)'(TABLE_LEN);

  logic [3:0]        state;
  logic [31:0]       cnt;
  logic [31:0]       delay_len;
  logic [ADDR_W-1:0] index;
  logic [7:0]        reg_q, val_q;
  logic [ADDR_W:0]   next_idx;

  // One-wider increment so TABLE_LEN == 2**ADDR_W ends the walk without wrapping index
  assign next_idx = {1'b0, index} + (ADDR_W+1)'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_PWRDN;
      cnt         <= '0;
      delay_len   <= '0;
      index       <= '0;
      reg_q       <= '0;
      val_q       <= '0;
      writes_done <= '0;
    end else begin
      case (state)
        S_PWRDN:
          if (cnt == 32'(PWRUP_CYCLES-1)) begin state <= S_RST; cnt <= '0; end
          else cnt <= cnt + 32'd1;
        S_RST:
          if (cnt == 32'(RESET_CYCLES-1)) begin state <= S_SETTLE; cnt <= '0; end
          else cnt <= cnt + 32'd1;
        S_SETTLE:
          if (cnt == 32'(SETTLE_CYCLES-1)) begin state <= S_FETCH; cnt <= '0; end
          else cnt <= cnt + 32'd1;
        S_FETCH: state <= S_DECODE;
        S_DECODE: begin
          cnt <= '0;
          if (rom_data == END_TAG || {1'b0, index} == LAST) state <= S_DONE;
          else if (rom_data[15:8] == DELAY_TAG) begin
            delay_len <= 32'(rom_data[7:0]) * 32'(DELAY_UNIT);
            state     <= (rom_data[7:0] == 8'd0) ? S_ADVANCE : S_DELAY;
          end else begin
            reg_q <= rom_data[15:8];
            val_q <= rom_data[7:0];
            state <= S_SEND;
          end
        end
        S_DELAY:
          if (cnt == delay_len - 32'd1) begin state <= S_ADVANCE; cnt <= '0; end
          else cnt <= cnt + 32'd1;
        S_SEND:
          if (i2c_taken) begin
            state       <= S_GAP;
            cnt         <= '0;
            writes_done <= writes_done + (ADDR_W+1)'(1);
          end
`ifdef SCCB_WATCHDOG_EN
          else if (cnt == 32'(TIMEOUT_CYCLES-1)) state <= S_ERROR;
          else cnt <= cnt + 32'd1;
`endif
        S_GAP:
          if (cnt == 32'(GAP_CYCLES-1)) begin state <= S_ADVANCE; cnt <= '0; end
          else cnt <= cnt + 32'd1;
        S_ADVANCE:
          if (next_idx == LAST) state <= S_DONE;
          else begin
            index <= next_idx[ADDR_W-1:0];
            state <= S_FETCH;
          end
        S_DONE, S_ERROR:
          if (restart) begin
            state       <= S_PWRDN;
            cnt         <= '0;
            index       <= '0;
            writes_done <= '0;
          end
        default: state <= S_PWRDN;
      endcase
    end
  end

  assign rom_addr  = index;
  assign i2c_send  = (state == S_SEND);
  assign i2c_id    = DEV_ID;
  assign i2c_reg   = reg_q;
  assign i2c_value = val_q;
  assign cam_pwdn  = (state == S_PWRDN);
  assign cam_reset = (state == S_PWRDN) || (state == S_RST);
  assign busy      = !((state == S_DONE) || (state == S_ERROR));
  assign done      = (state == S_DONE);
`ifdef SCCB_WATCHDOG_EN
  assign error     = (state == S_ERROR);
`else
  assign error     = 1'b0;
`endif

endmodule

// File: tb/tb_ov7670_seq_controller.sv
// Randomized bench for ov7670_seq_controller against a phase-duration reference model.
module tb_ov7670_seq_controller;
  localparam int AW = 3;
  localparam int TL = 4;

  logic          clk = 1'b0;
  logic          reset, restart, i2c_taken;
  logic [AW-1:0] rom_addr;
  logic [15:0]   rom_data;
  logic          i2c_send, cam_pwdn, cam_reset, busy, done, error;
  logic [7:0]    i2c_id, i2c_reg, i2c_value;
  logic [AW:0]   writes_done;

  always #5 clk = ~clk;

  ov7670_seq_controller #(
    .ADDR_W(AW), .TABLE_LEN(TL), .DEV_ID(8'h42), .PWRUP_CYCLES(4), .RESET_CYCLES(4),
    .SETTLE_CYCLES(8), .GAP_CYCLES(2), .DELAY_TAG(8'hF0), .DELAY_UNIT(3),
    .END_TAG(16'hFFFF), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset), .restart(restart), .rom_addr(rom_addr), .rom_data(rom_data),
    .i2c_send(i2c_send), .i2c_taken(i2c_taken), .i2c_id(i2c_id), .i2c_reg(i2c_reg),
    .i2c_value(i2c_value), .cam_pwdn(cam_pwdn), .cam_reset(cam_reset), .busy(busy),
    .done(done), .error(error), .writes_done(writes_done)
  );

  logic [15:0] rom [8];
  always @(posedge clk) rom_data <= rom[rom_addr];

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // monitor / responder state
  int cyc, age, lat, rises, cur_len, pwdn_fall, rst_fall, done_cyc, err_cyc, max_addr, stab_err;
  bit spurious, prev_send, hit;
  logic [7:0] q_reg[$], q_val[$];
  int q_cyc[$], q_len[$];
  // reference model results
  logic [7:0] e_reg[$], e_val[$];
  int e_cyc[$], e_done, e_max;

  task automatic mon_clear();
    cyc = 0; age = 0; rises = 0; cur_len = 0; prev_send = 0; i2c_taken = 1'b0;
    pwdn_fall = -1; rst_fall = -1; done_cyc = -1; err_cyc = -1; max_addr = 0; stab_err = 0;
    q_reg.delete(); q_val.delete(); q_cyc.delete(); q_len.delete();
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (i2c_send) begin
      if (!prev_send) begin
        q_reg.push_back(i2c_reg); q_val.push_back(i2c_value); q_cyc.push_back(cyc);
        cur_len = 0; rises++;
      end else if (i2c_reg != q_reg[$] || i2c_value != q_val[$]) stab_err++;
      cur_len++; age++;
      i2c_taken = (lat != 0 && age == lat);
    end else begin
      if (prev_send) q_len.push_back(cur_len);
      age = 0;
      i2c_taken = spurious && ($urandom_range(7) == 0);
    end
    prev_send = i2c_send;
    if (!cam_pwdn && pwdn_fall < 0) pwdn_fall = cyc;
    if (!cam_reset && rst_fall < 0) rst_fall = cyc;
    if (int'(rom_addr) > max_addr) max_addr = int'(rom_addr);
    if (done && done_cyc < 0) done_cyc = cyc;
    if (error && err_cyc < 0) err_cyc = cyc;
  endtask

  task automatic run(input int budget, input int stop_rises, output bit h);
    h = 0;
    for (int k = 0; k < budget; k++) begin
      step();
      if (done || error || (stop_rises != 0 && rises == stop_rises)) begin h = 1; break; end
    end
  endtask

  task automatic start_reset();
    @(negedge clk); reset = 1'b1; restart = 1'b0;
    @(negedge clk); @(negedge clk);
    reset = 1'b0;
    mon_clear();
  endtask

  // Sequence as a sum of phase durations: 16 cycles of power-up, then per entry
  // fetch+decode (2), plus send(lat)+gap(2)+advance(1) or delay(v*3)+advance(1).
  task automatic model();
    int t;
    t = 16; e_done = -1; e_max = 0;
    e_reg.delete(); e_val.delete(); e_cyc.delete();
    for (int i = 0; i < TL; i++) begin
      e_max = i;
      if (rom[i] == 16'hFFFF) begin e_done = t + 2; break; end
      if (rom[i][15:8] == 8'hF0) t += 3 * int'(rom[i][7:0]) + 3;
      else begin
        e_reg.push_back(rom[i][15:8]); e_val.push_back(rom[i][7:0]); e_cyc.push_back(t + 2);
        t += lat + 5;
      end
    end
    if (e_done < 0) e_done = t;
  endtask

  task automatic compare(input string nm);
    chk({nm, ".finished"}, 32'(hit), 32'd1);
    chk({nm, ".nwr"}, q_reg.size(), e_reg.size());
    chk({nm, ".nlen"}, q_len.size(), e_reg.size());
    for (int i = 0; i < e_reg.size() && i < q_reg.size() && i < q_len.size(); i++) begin
      chk($sformatf("%s.reg%0d", nm, i), q_reg[i], e_reg[i]);
      chk($sformatf("%s.val%0d", nm, i), q_val[i], e_val[i]);
      chk($sformatf("%s.at%0d", nm, i), q_cyc[i], e_cyc[i]);
      chk($sformatf("%s.len%0d", nm, i), q_len[i], lat);
    end
    chk({nm, ".done_at"}, done_cyc, e_done);
    chk({nm, ".writes_done"}, writes_done, e_reg.size());
    chk({nm, ".busy"}, busy, 1'b0);
    chk({nm, ".pwdn_dn"}, {cam_pwdn, cam_reset}, 2'b00);
    chk({nm, ".pwdn_fall"}, pwdn_fall, 4);
    chk({nm, ".rst_fall"}, rst_fall, 8);
    chk({nm, ".max_addr"}, max_addr, e_max);
    chk({nm, ".stable"}, stab_err, 0);
    chk({nm, ".error"}, error, 1'b0);
    chk({nm, ".id"}, i2c_id, 8'h42);
  endtask

  task automatic fill_plain();
    for (int i = 0; i < 8; i++) rom[i] = {8'($urandom_range(0, 8'hEF)), 8'($urandom)};
  endtask

  task automatic fill_mixed();
    int r;
    for (int i = 0; i < 8; i++) begin
      r = $urandom_range(7);
      if (r == 0) rom[i] = {8'hF0, 8'($urandom_range(0, 6))};
      else if (r == 1) rom[i] = 16'hFFFF;
      else rom[i] = {8'($urandom_range(0, 8'hEF)), 8'($urandom)};
    end
  endtask

  initial begin
    reset = 1'b1; restart = 1'b0; i2c_taken = 1'b0; lat = 3; spurious = 0;
    fill_plain();
    mon_clear();
    repeat (3) @(negedge clk);
    chk("rst.pwdn", cam_pwdn, 1'b1);
    chk("rst.camrst", cam_reset, 1'b1);
    chk("rst.busy", busy, 1'b1);
    chk("rst.done_err", {done, error}, 2'b00);
    chk("rst.send", i2c_send, 1'b0);
    chk("rst.addr", rom_addr, 3'd0);
    chk("rst.wd", writes_done, 4'd0);

    // fixed table with END_TAG
    rom[0] = 16'h1280; rom[1] = 16'h1204; rom[2] = 16'h3A04; rom[3] = 16'hFFFF;
    lat = 3; start_reset(); model(); run(3000, 0, hit); compare("end_tag");

    // leading delay entry, then exhaustion by TABLE_LEN
    rom[0] = 16'hF005; rom[1] = 16'h1280; rom[2] = 16'h1204; rom[3] = 16'h3A04;
    start_reset(); model(); run(3000, 0, hit); compare("delay");
    chk("delay.first_at", e_cyc.size() > 0 ? e_cyc[0] : -1, 36);

    // four plain entries, random latency and stray taken pulses
    fill_plain(); lat = $urandom_range(1, 4); spurious = 1;
    start_reset(); model(); run(3000, 0, hit); compare("plain");

    for (int n = 0; n < 4; n++) begin
      fill_mixed(); lat = $urandom_range(1, 4);
      start_reset(); model(); run(3000, 0, hit); compare($sformatf("mix%0d", n));
    end

    // reset during the second SEND
    fill_plain(); lat = 3; spurious = 0;
    start_reset(); run(3000, 2, hit);
    chk("midrst.reached", 32'(hit), 32'd1);
    reset = 1'b1;
    step();
    chk("midrst.send", i2c_send, 1'b0);
    chk("midrst.pwdn", {cam_pwdn, cam_reset}, 2'b11);
    chk("midrst.wd", writes_done, 4'd0);
    chk("midrst.addr", rom_addr, 3'd0);
    reset = 1'b0; mon_clear();
    model(); run(3000, 0, hit); compare("midrst");

    // restart while busy is ignored; restart in DONE repeats the sequence
    fill_plain(); lat = 2;
    start_reset(); model();
    run(10, 0, hit);
    restart = 1'b1; step(); restart = 1'b0;
    run(3000, 0, hit); compare("rs_busy");
    restart = 1'b1; step();
    chk("rs_done.done", done, 1'b0);
    chk("rs_done.busy", busy, 1'b1);
    chk("rs_done.pwdn", cam_pwdn, 1'b1);
    chk("rs_done.wd", writes_done, 4'd0);
    restart = 1'b0; mon_clear();
    run(3000, 0, hit); compare("rs_again");

`ifdef SCCB_WATCHDOG_EN
    rom[0] = 16'h1280; rom[1] = 16'h1204; rom[2] = 16'h3A04; rom[3] = 16'hFFFF;
    lat = 0;
    start_reset(); run(3000, 0, hit);
    chk("wdog.finished", 32'(hit), 32'd1);
    chk("wdog.error", error, 1'b1);
    chk("wdog.done", done, 1'b0);
    chk("wdog.busy", busy, 1'b0);
    chk("wdog.send", i2c_send, 1'b0);
    chk("wdog.err_at", err_cyc, 38);
    chk("wdog.len", q_len.size() > 0 ? q_len[0] : -1, 20);
    restart = 1'b1; step(); restart = 1'b0;
    chk("wdog.clr", {error, busy}, 2'b01);
    lat = 3; mon_clear(); model(); run(3000, 0, hit); compare("wdog_rerun");
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
